// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the scpu EX stage.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply path.
module ex_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        flush,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  rd_addr,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  rd_addr_out
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    state_t      state_q;
    logic [2:0]  op_q;
    logic [4:0]  cnt_q;
    logic [63:0] acc_q;
    logic [31:0] m_q;
    logic        neg_q;
    logic [4:0]  rd_q;
    logic [31:0] res_q;
    logic [4:0]  rdo_q;
    logic        done_q;

    logic        is_div;
    logic        a_sgn;
    logic        b_sgn;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        neg_d;
    logic        div_zero;
    logic        div_ovf;
    logic [31:0] spec_res;

    always_comb begin
        is_div = funct3[2];
        a_sgn  = rs1_data[31] & ((funct3 == OP_MULH) | (funct3 == OP_MULHSU) |
                                 (funct3 == OP_DIV)  | (funct3 == OP_REM));
        b_sgn  = rs2_data[31] & ((funct3 == OP_MULH) | (funct3 == OP_DIV) |
                                 (funct3 == OP_REM));
        a_mag  = a_sgn ? (32'd0 - rs1_data) : rs1_data;
        b_mag  = b_sgn ? (32'd0 - rs2_data) : rs2_data;
        // Remainder follows the dividend; everything else follows sign parity.
        neg_d  = (funct3 == OP_REM) ? a_sgn : (a_sgn ^ b_sgn);
        div_zero = is_div & (rs2_data == 32'd0);
        div_ovf  = ((funct3 == OP_DIV) | (funct3 == OP_REM)) &
                   (rs1_data == 32'h8000_0000) & (rs2_data == 32'hFFFF_FFFF);
        if (div_zero)
            spec_res = funct3[1] ? rs1_data : 32'hFFFF_FFFF;
        else
            spec_res = funct3[1] ? 32'd0 : 32'h8000_0000;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] fprod;
    logic [31:0] fres;

    // Low 64 bits of a sign-extended 64x64 product equal the true product.
    always_comb begin
        fprod = {{32{a_sgn}}, rs1_data} * {{32{b_sgn}}, rs2_data};
        fres  = (funct3 == OP_MUL) ? fprod[31:0] : fprod[63:32];
    end
`endif

    logic [32:0] msum;
    logic [32:0] dtop;
    logic        dge;
    logic [31:0] dsub;
    logic [63:0] acc_d;
    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] res_d;

    always_comb begin
        msum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, m_q} : 33'd0);
        dtop  = acc_q[63:31];
        dge   = dtop >= {1'b0, m_q};
        dsub  = dtop[31:0] - m_q;
        if (op_q[2])
            acc_d = {(dge ? dsub : dtop[31:0]), acc_q[30:0], dge};
        else
            acc_d = {msum, acc_q[31:1]};
        prod = neg_q ? (64'd0 - acc_d) : acc_d;
        quo  = acc_d[31:0];
        rem  = acc_d[63:32];
        unique case (op_q)
            OP_MUL:    res_d = prod[31:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  res_d = prod[63:32];
            OP_DIV:    res_d = neg_q ? (32'd0 - quo) : quo;
            OP_DIVU:   res_d = quo;
            OP_REM:    res_d = neg_q ? (32'd0 - rem) : rem;
            OP_REMU:   res_d = rem;
            default:   res_d = quo;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= 3'd0;
            cnt_q   <= 5'd0;
            acc_q   <= 64'd0;
            m_q     <= 32'd0;
            neg_q   <= 1'b0;
            rd_q    <= 5'd0;
            res_q   <= 32'd0;
            rdo_q   <= 5'd0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start && !flush) begin
                        op_q  <= funct3;
                        rd_q  <= rd_addr;
                        neg_q <= neg_d;
                        cnt_q <= 5'd0;
                        if (div_zero || div_ovf) begin
                            res_q   <= spec_res;
                            rdo_q   <= rd_addr;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!is_div) begin
                            res_q   <= fres;
                            rdo_q   <= rd_addr;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
`endif
                        else begin
                            acc_q   <= {32'd0, is_div ? a_mag : b_mag};
                            m_q     <= is_div ? b_mag : a_mag;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        state_q <= IDLE;
                        cnt_q   <= 5'd0;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            res_q   <= res_d;
                            rdo_q   <= rd_q;
                            done_q  <= 1'b1;
                            cnt_q   <= 5'd0;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = (state_q == CALC) |
                         ((state_q == IDLE) & start & ~flush);
    assign done        = done_q;
    assign result      = res_q;
    assign rd_addr_out = rdo_q;

endmodule
